sgm_path_sequencer: RTL and testbench

SGM_PATH_SEQUENCER -- requirements
Module: sgm_path_sequencer

---
 rtl/sgm_path_sequencer_pkg.sv | 22 ++
 rtl/sgm_cfg_shadow.sv | 56 +++++
 rtl/sgm_path_sequencer.sv | 139 +++++++++++++
 tb/tb_sgm_path_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_path_sequencer_pkg.sv
// Shared definitions for the SGM path sequencer: FSM encoding, default
// penalties and the edge helpers used on the video timing inputs.
package sgm_path_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_BLANK      = 2'd1,
    ST_ACTIVE     = 2'd2
  } seq_state_t;

  localparam logic [7:0] DEFAULT_P1 = 8'd15;
  localparam logic [7:0] DEFAULT_P2 = 8'd64;

  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic fall_edge(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/sgm_cfg_shadow.sv
// Penalty handshake: a transfer is parked in a pending register and only
// becomes visible on p1/p2 at the next frame start.
module sgm_cfg_shadow
  import sgm_path_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_p1,
  input  logic [7:0] cfg_p2,
  output logic       cfg_ready,
  output logic [7:0] p1,
  output logic [7:0] p2
);

  logic [7:0] pend_p1;
  logic [7:0] pend_p2;
  logic       pend_valid;
  logic       apply_q;
  logic       rearm_q;

  // frame_start is the raw pin edge; a transfer on that same edge is not yet
  // pending, so it waits for the following frame. Applying one cycle later
  // lines p1/p2 up with the rest of the registered video outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready  <= 1'b1;
      pend_p1    <= '0;
      pend_p2    <= '0;
      pend_valid <= 1'b0;
      apply_q    <= 1'b0;
      rearm_q    <= 1'b0;
      p1         <= DEFAULT_P1;
      p2         <= DEFAULT_P2;
    end else begin
      apply_q <= pend_valid & frame_start;
      rearm_q <= apply_q;
      if (cfg_valid && cfg_ready) begin
        pend_p1    <= cfg_p1;
        pend_p2    <= cfg_p2;
        pend_valid <= 1'b1;
        cfg_ready  <= 1'b0;
      end
      if (apply_q) begin
        p1         <= pend_p1;
        p2         <= pend_p2;
        pend_valid <= 1'b0;
      end
      if (rearm_q) begin
        cfg_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgm_path_sequencer.sv
// Tracks row/column of the incoming cost stream and emits the SGM path
// beginning strobes plus the right-half data enable.
module sgm_path_sequencer
  import sgm_path_sequencer_pkg::*;
#(
  parameter int ACTIVE_WIDTH   = 1280,
  parameter int HALF_IMG_WIDTH = 640,
  parameter int ROW_WIDTH      = 10,
  parameter int COL_WIDTH      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de_in,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic                 cfg_valid,
  input  logic [7:0]           cfg_p1,
  input  logic [7:0]           cfg_p2,
  output logic                 cfg_ready,
  output logic [ROW_WIDTH-1:0] row_out,
  output logic [COL_WIDTH-1:0] col_out,
  output logic                 half_de_out,
  output logic                 ext_half_de_out,
  output logic                 beg_h,
  output logic                 beg_t2b,
  output logic                 beg_l2r,
  output logic                 beg_r2l,
  output logic [7:0]           p1_out,
  output logic [7:0]           p2_out,
  output logic                 line_err
);

  localparam logic [COL_WIDTH-1:0] COL_MAX  = '1;
  localparam logic [ROW_WIDTH-1:0] ROW_MAX  = '1;
  localparam logic [COL_WIDTH-1:0] HALF_COL = COL_WIDTH'(HALF_IMG_WIDTH);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(2 * HALF_IMG_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] LINE_LEN = COL_WIDTH'(ACTIVE_WIDTH);

  seq_state_t           state;
  logic                 de_q;
  logic                 vs_q;
  logic                 vs_qq;
  logic [COL_WIDTH-1:0] col_cnt;

  // Horizontal sync carries no information the de edges do not already give.
  logic unused_hsync;
  assign unused_hsync = h_sync_in;

  logic vs_rise;
  logic vs_pin_rise;
  logic pix;
  logic half_next;
  logic h_next;
  logic t2b_next;
  logic r2l_next;

  assign vs_rise     = rise_edge(vs_q, vs_qq);
  assign vs_pin_rise = rise_edge(v_sync_in, vs_q);
  assign pix         = de_q && (state != ST_WAIT_FRAME) && !vs_rise;
  assign half_next   = pix && (col_cnt >= HALF_COL);
  assign h_next      = pix && (col_cnt == HALF_COL);
  assign t2b_next    = pix && (row_out == '0);
  assign r2l_next    = pix && (col_cnt == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_WAIT_FRAME;
      de_q            <= 1'b0;
      vs_q            <= 1'b0;
      vs_qq           <= 1'b0;
      col_cnt         <= '0;
      row_out         <= '0;
      col_out         <= '0;
      half_de_out     <= 1'b0;
      ext_half_de_out <= 1'b0;
      beg_h           <= 1'b0;
      beg_t2b         <= 1'b0;
      beg_l2r         <= 1'b0;
      beg_r2l         <= 1'b0;
      line_err        <= 1'b0;
    end else begin
      de_q            <= de_in;
      vs_q            <= v_sync_in;
      vs_qq           <= vs_q;
      half_de_out     <= half_next;
      ext_half_de_out <= half_next | half_de_out;
      beg_h           <= h_next;
      beg_t2b         <= t2b_next;
      beg_l2r         <= h_next | t2b_next;
      beg_r2l         <= r2l_next | t2b_next;
      if (vs_rise) begin
        state    <= ST_BLANK;
        row_out  <= '0;
        col_cnt  <= '0;
        col_out  <= '0;
        line_err <= 1'b0;
      end else begin
        case (state)
          ST_BLANK: begin
            if (de_q) begin
              state   <= ST_ACTIVE;
              col_out <= col_cnt;
              col_cnt <= (col_cnt == COL_MAX) ? col_cnt : col_cnt + COL_WIDTH'(1);
            end
          end
          ST_ACTIVE: begin
            if (de_q) begin
              col_out <= col_cnt;
              col_cnt <= (col_cnt == COL_MAX) ? col_cnt : col_cnt + COL_WIDTH'(1);
            end else begin
              // de falling edge closes the line
              state   <= ST_BLANK;
              col_cnt <= '0;
              col_out <= '0;
              row_out <= (row_out == ROW_MAX) ? row_out : row_out + ROW_WIDTH'(1);
              if (col_cnt != LINE_LEN) begin
                line_err <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  sgm_cfg_shadow u_cfg_shadow (
    .clk         (clk),
    .rst         (rst),
    .frame_start (vs_pin_rise),
    .cfg_valid   (cfg_valid),
    .cfg_p1      (cfg_p1),
    .cfg_p2      (cfg_p2),
    .cfg_ready   (cfg_ready),
    .p1          (p1_out),
    .p2          (p2_out)
  );

endmodule

// File: tb/tb_sgm_path_sequencer.sv
// Directed plus randomized frames for sgm_path_sequencer (8-pixel lines),
// checked against a line/pixel level reference model.
module tb_sgm_path_sequencer;

  localparam int AW = 8;
  localparam int HW = 4;
  localparam int RW = 10;
  localparam int CW = 11;
  localparam int COL_MAX = (1 << CW) - 1;
  localparam int ROW_MAX = (1 << RW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_p1 = '0, cfg_p2 = '0;
  logic          cfg_ready;
  logic [RW-1:0] row_out;
  logic [CW-1:0] col_out;
  logic          half_de_out, ext_half_de_out;
  logic          beg_h, beg_t2b, beg_l2r, beg_r2l;
  logic [7:0]    p1_out, p2_out;
  logic          line_err;

  sgm_path_sequencer #(
    .ACTIVE_WIDTH   (AW),
    .HALF_IMG_WIDTH (HW),
    .ROW_WIDTH      (RW),
    .COL_WIDTH      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .de_in           (de_in),
    .h_sync_in       (h_sync_in),
    .v_sync_in       (v_sync_in),
    .cfg_valid       (cfg_valid),
    .cfg_p1          (cfg_p1),
    .cfg_p2          (cfg_p2),
    .cfg_ready       (cfg_ready),
    .row_out         (row_out),
    .col_out         (col_out),
    .half_de_out     (half_de_out),
    .ext_half_de_out (ext_half_de_out),
    .beg_h           (beg_h),
    .beg_t2b         (beg_t2b),
    .beg_l2r         (beg_l2r),
    .beg_r2l         (beg_r2l),
    .p1_out          (p1_out),
    .p2_out          (p2_out),
    .line_err        (line_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // reference model: frame / line / pixel bookkeeping
  typedef struct {
    int col;
    int row;
    bit half;
    bit ext;
    bit bh;
    bit bt;
    bit bl;
    bit br;
    bit err;
  } vid_t;

  vid_t exp_v;
  bit   m_prev_vs, m_framed, m_in_line, m_err;
  int   m_pix, m_line;
  bit   m_ready, m_has_pend;
  int   m_p1, m_p2, m_pend_p1, m_pend_p2;
  int   apply_at, ready_at;

  function automatic void model_reset();
    exp_v      = '{default: 0};
    m_prev_vs  = 0;
    m_framed   = 0;
    m_in_line  = 0;
    m_err      = 0;
    m_pix      = 0;
    m_line     = 0;
    m_ready    = 1;
    m_has_pend = 0;
    m_p1       = 15;
    m_p2       = 64;
    m_pend_p1  = 0;
    m_pend_p2  = 0;
    apply_at   = -1;
    ready_at   = -1;
  endfunction

  task automatic check_video(input vid_t e);
    check("row_out", row_out, e.row);
    check("col_out", col_out, e.col);
    check("half_de_out", half_de_out, e.half);
    check("ext_half_de_out", ext_half_de_out, e.ext);
    check("beg_h", beg_h, e.bh);
    check("beg_t2b", beg_t2b, e.bt);
    check("beg_l2r", beg_l2r, e.bl);
    check("beg_r2l", beg_r2l, e.br);
    check("line_err", line_err, e.err);
  endtask

  task automatic check_cfg();
    check("cfg_ready", cfg_ready, m_ready);
    check("p1_out", p1_out, m_p1);
    check("p2_out", p2_out, m_p2);
  endtask

  // driver: one clock cycle with the given inputs
  task automatic cycle(input bit de, input bit vs, input bit cv = 0,
                       input int p1 = 0, input int p2 = 0);
    vid_t nxt;
    bit   rise;
    de_in     = de;
    v_sync_in = vs;
    h_sync_in = !de;
    cfg_valid = cv;
    cfg_p1    = p1[7:0];
    cfg_p2    = p2[7:0];

    rise = vs && !m_prev_vs;
    if (rise && m_has_pend) begin
      apply_at = edge_n + 2;
      ready_at = edge_n + 3;
    end
    if (cv && m_ready) begin
      m_pend_p1  = p1 & 255;
      m_pend_p2  = p2 & 255;
      m_has_pend = 1;
      m_ready    = 0;
    end

    nxt = '{default: 0};
    if (rise) begin
      m_framed  = 1;
      m_line    = 0;
      m_pix     = 0;
      m_err     = 0;
      m_in_line = 0;
    end else if (m_framed) begin
      if (de) begin
        nxt.col  = m_pix;
        nxt.half = (m_pix >= HW);
        nxt.bh   = (m_pix == HW);
        nxt.bt   = (m_line == 0);
        nxt.bl   = nxt.bh || nxt.bt;
        nxt.br   = (m_pix == 2 * HW - 1) || nxt.bt;
        if (m_pix < COL_MAX) m_pix++;
        m_in_line = 1;
      end else if (m_in_line) begin
        if (m_pix != AW) m_err = 1;
        if (m_line < ROW_MAX) m_line++;
        m_pix     = 0;
        m_in_line = 0;
      end
    end
    nxt.row   = m_line;
    nxt.err   = m_err;
    nxt.ext   = nxt.half || exp_v.half;
    m_prev_vs = vs;

    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n == apply_at) begin
      m_p1       = m_pend_p1;
      m_p2       = m_pend_p2;
      m_has_pend = 0;
    end
    if (edge_n == ready_at) m_ready = 1;
    check_video(exp_v);
    check_cfg();
    exp_v = nxt;
  endtask

  task automatic do_reset();
    vid_t zero;
    zero      = '{default: 0};
    rst       = 1'b1;
    de_in     = 1'b0;
    v_sync_in = 1'b0;
    h_sync_in = 1'b0;
    cfg_valid = 1'b0;
    #2;
    model_reset();
    check_video(zero);
    check_cfg();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_line(input int n, input int gap);
    for (int i = 0; i < n; i++) cycle(1, 0);
    for (int i = 0; i < gap; i++) cycle(0, 0);
  endtask

  task automatic drive_line_cfg(input int n, input int gap, input int at, input int p1, input int p2);
    for (int i = 0; i < n; i++) cycle(1, 0, (i == at), p1, p2);
    for (int i = 0; i < gap; i++) cycle(0, 0);
  endtask

  task automatic vsync(input int hi, input int blank);
    for (int i = 0; i < hi; i++) cycle(0, 1);
    for (int i = 0; i < blank; i++) cycle(0, 0);
  endtask

  task automatic rand_line();
    int n;
    n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 9)) : AW;
    for (int i = 0; i < n; i++)
      cycle(1, 0, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) cycle(0, 0);
  endtask

  initial begin
    #1;
    do_reset();
    // de before any frame start must be ignored
    drive_line(AW, 3);
    // three clean lines, penalty offer in the middle line
    vsync(2, 3);
    drive_line(AW, 3);
    drive_line_cfg(AW, 3, 2, 20, 80);
    drive_line(AW, 4);
    vsync(2, 3);
    // short line raises line_err until the next frame
    drive_line(AW - 1, 3);
    drive_line(AW, 3);
    drive_line(AW, 3);
    vsync(1, 2);
    drive_line(AW, 2);
    // offer coinciding with the frame start edge
    cycle(0, 1, 1, 33, 99);
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 0);
    drive_line(AW, 3);
    drive_line(AW, 2);
    vsync(2, 2);
    drive_line(AW, 3);
    vsync(2, 2);
    drive_line(AW, 2);
    // randomized frames
    repeat (4) begin
      vsync(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(2, 4)) rand_line();
    end
    // reset in the middle of row 1
    vsync(2, 2);
    drive_line(AW, 3);
    for (int i = 0; i < 5; i++) cycle(1, 0);
    do_reset();
    drive_line(AW, 3);
    drive_line(AW, 3);
    vsync(2, 2);
    drive_line(AW, 2);
    drive_line(AW, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
